// File: rtl/instruction_issue_unit.sv
// instruction_issue_unit
//   Buffers program words pushed by a loader in a DEPTH-entry FIFO and feeds
//   them to the core one at a time. Each word is presented with a one-cycle
//   read strobe. The next word is not issued until the core acknowledges the
//   current one with done_in, or until the wait times out.
//
// Ports
//   clk             : clock, rising edge
//   resetn          : synchronous reset, active HIGH (1 = reset)
//   wr_en/wr_data   : loader push
//   flush           : clear FIFO, abort any in-flight wait
//   enable          : allow new issues
//   done_in         : core completion acknowledge
//   instruction_out : word presented to the core
//   read_out        : one-cycle strobe, instruction_out valid
//   full/empty/count: FIFO status, from the registered occupancy
//   issued_count    : number of acknowledged instructions (wraps)
//   overflow_err    : sticky, push attempted while full
//   timeout_err     : sticky, no done_in within TIMEOUT cycles
module instruction_issue_unit #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  input  logic              flush,
  input  logic              enable,
  input  logic              done_in,
  output logic [31:0]       instruction_out,
  output logic              read_out,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [15:0]       issued_count,
  output logic              overflow_err,
  output logic              timeout_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       instr_q, instr_d;
  logic              read_q, read_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       issued_q, issued_d;
  logic              ovf_q, ovf_d;
  logic              to_q, to_d;
  logic              push, pop, is_full;

  assign is_full = (count_q == (ADDR_W+1)'(DEPTH));
  // A push against a full FIFO is dropped even if a pop frees a slot
  // on the same edge: acceptance looks only at the registered count.
  assign push    = wr_en && !is_full;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    read_d   = 1'b0;
    timer_d  = timer_q;
    issued_d = issued_q;
    ovf_d    = ovf_q | (wr_en & is_full);
    to_d     = to_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && count_q != '0) begin
          instr_d = mem_q[rd_ptr_q];
          read_d  = 1'b1;
          pop     = 1'b1;
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // done_in counts even on the strobe cycle itself.
        if (done_in) begin
          issued_d = issued_q + 16'd1;
          state_d  = IDLE;
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= '0;
      read_q   <= 1'b0;
      timer_q  <= '0;
      issued_q <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else if (flush) begin
      // Flush drops queued words and any wait; counters and flags survive.
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      read_q   <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      read_q   <= read_d;
      timer_q  <= timer_d;
      issued_q <= issued_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (!resetn && !flush && push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign instruction_out = instr_q;
  assign read_out        = read_q;
  assign full            = is_full;
  assign empty           = (count_q == '0);
  assign count           = count_q;
  assign issued_count    = issued_q;
  assign overflow_err    = ovf_q;
  assign timeout_err     = to_q;

endmodule

// File: tb/tb_instruction_issue_unit.sv
module tb_instruction_issue_unit;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TO    = 8;

  logic        clk = 1'b0;
  logic        resetn, wr_en, flush, enable, done_in;
  logic [31:0] wr_data;
  logic [31:0] instruction_out;
  logic        read_out, full, empty, overflow_err, timeout_err;
  logic [AW:0] count;
  logic [15:0] issued_count;

  instruction_issue_unit #(.DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .enable(enable), .done_in(done_in),
    .instruction_out(instruction_out), .read_out(read_out), .full(full),
    .empty(empty), .count(count), .issued_count(issued_count),
    .overflow_err(overflow_err), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of pending words plus "busy waiting for done".
  logic [31:0] mq[$];
  bit          m_busy;
  logic [31:0] m_instr;
  bit          m_rd;
  int          m_wait;
  int          m_iss;
  bit          m_ovf, m_to;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  n;
    bit  issue;
    if (resetn) begin
      mq.delete(); m_busy = 0; m_instr = '0; m_rd = 0; m_wait = 0;
      m_iss = 0; m_ovf = 0; m_to = 0;
    end else if (flush) begin
      mq.delete(); m_busy = 0; m_rd = 0; m_wait = 0;
    end else begin
      n = mq.size();
      issue = !m_busy && enable && n > 0;
      if (wr_en && n == DEPTH) m_ovf = 1;
      m_rd = 0;
      if (m_busy) begin
        m_wait++;
        if (done_in) begin
          m_iss = (m_iss + 1) % 65536; m_busy = 0;
        end else if (m_wait == TO) begin
          m_to = 1; m_busy = 0;
        end
      end else if (issue) begin
        m_instr = mq.pop_front(); m_rd = 1; m_busy = 1; m_wait = 0;
      end
      if (wr_en && n < DEPTH) mq.push_back(wr_data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("instruction_out", instruction_out, m_instr);
    chk("read_out", 32'(read_out), 32'(m_rd));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("issued_count", 32'(issued_count), 32'(m_iss));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_data = '0; flush = 0; enable = 0; done_in = 0; resetn = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); resetn = 1; step(); resetn = 0;
  endtask

  task automatic push(logic [31:0] w);
    wr_en = 1; wr_data = w; step(); wr_en = 0;
  endtask

  // Step until a read strobe is seen; an expired budget is a failure.
  task automatic wait_read(string tag);
    int n = 0;
    while (!read_out && n < 60) begin step(); n++; end
    chk(tag, 32'(read_out), 32'd1);
  endtask

  logic [31:0] prog [3] = '{32'h00000013, 32'h00500093, 32'h00A00113};
  logic [31:0] words[$];
  int          n;

  initial begin
    idle_inputs();
    resetn = 1;
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    resetn = 0;

    // Three-word program, done two cycles after each strobe.
    foreach (prog[i]) push(prog[i]);
    chk("prog_count", 32'(count), 3);
    enable = 1;
    for (int i = 0; i < 3; i++) begin
      wait_read("prog_read");
      chk("prog_word", instruction_out, prog[i]);
      step();
      chk("prog_strobe_once", 32'(read_out), 0);
      step();
      chk("prog_hold", instruction_out, prog[i]);
      done_in = 1; step(); done_in = 0;
    end
    step();
    chk("prog_issued", 32'(issued_count), 3);
    chk("prog_empty", 32'(empty), 1);

    // Overfill, then drain with done tied high; do it twice to wrap pointers.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      words.delete();
      for (int i = 0; i < DEPTH + 1; i++) begin
        words.push_back($urandom);
        push(words[i]);
      end
      chk("ovf_full", 32'(full), 1);
      chk("ovf_count", 32'(count), DEPTH);
      chk("ovf_err", 32'(overflow_err), 1);
      enable = 1; done_in = 1;
      for (int i = 0; i < DEPTH; i++) begin
        wait_read("drain_read");
        chk("drain_word", instruction_out, words[i]);
        chk("drain_issued", 32'(issued_count), i);
        push($urandom);  // refill behind the drain, exercising wrap
      end
      enable = 0; done_in = 0;
      repeat (3) step();
    end

    // Timeout: done held low.
    do_reset();
    push(32'hAAAA0001); push(32'hAAAA0002);
    enable = 1;
    wait_read("to_read");
    n = 0;
    while (!timeout_err && n < 4 * TO) begin step(); n++; end
    chk("to_latency", n, TO);
    chk("to_issued", 32'(issued_count), 0);
    wait_read("to_next_read");
    chk("to_next_word", instruction_out, 32'hAAAA0002);
    enable = 0; done_in = 1; step(); done_in = 0;

    // Flush during WAIT with a simultaneous push.
    do_reset();
    for (int i = 0; i < 6; i++) push(32'hB0 + i);
    enable = 1;
    wait_read("fl_read");
    flush = 1; wr_en = 1; wr_data = 32'hDEAD; step(); flush = 0; wr_en = 0;
    chk("fl_count", 32'(count), 0);
    chk("fl_read_low", 32'(read_out), 0);
    chk("fl_instr_kept", instruction_out, 32'hB0);
    repeat (5) step();
    chk("fl_issued", 32'(issued_count), 0);

    // Reset in the middle of a wait; a later done is ignored.
    for (int i = 0; i < 3; i++) push(32'hC0 + i);
    wait_read("rs_read");
    enable = 0;
    resetn = 1; step(); resetn = 0;
    chk("rs_instr", instruction_out, 0);
    done_in = 1; repeat (3) step(); done_in = 0;
    chk("rs_issued", 32'(issued_count), 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      wr_en   = ($urandom_range(0, 99) < 45);
      wr_data = $urandom;
      enable  = ($urandom_range(0, 99) < 75);
      done_in = ($urandom_range(0, 99) < 30);
      flush   = ($urandom_range(0, 59) == 0);
      resetn  = ($urandom_range(0, 399) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
